id_issue_stage: RTL and testbench

- Decode/issue stage sitting directly upstream of the core's pipelined ALU.
- Accepts 16-bit instructions and reads a 4x8 register file.
- Drives registered A/B/control to the ALU and tracks in-flight ops for ALU_LATENCY cycles.
- Writes each ALU result back to its destination register, with RAW-hazard stall and write-back bypass.

---
 rtl/id_issue_stage.sv | 132 +++++++++++++
 tb/tb_id_issue_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// Decode/issue stage in front of a pipelined ALU: reads a 4x8 register file,
// issues registered operands, tracks in-flight ops, and writes results back.
module id_issue_stage #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  control,
    output logic        issue_valid,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout,
    output logic        wb_valid,
    output logic [1:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        carry_flag
);

    localparam int         DEPTH   = ALU_LATENCY + 1;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;
    localparam logic [2:0] ALU_ADD = 3'b000;

    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic       imm_sel;
    logic [7:0] imm8;

    assign op      = instr[15:13];
    assign rd      = instr[12:11];
    assign rs1     = instr[10:9];
    assign imm_sel = instr[8];
    assign imm8    = instr[7:0];
    assign rs2     = instr[1:0];

    logic [7:0]       rf_q [4];
    logic [7:0]       rf_d [4];
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             carry_q, carry_d;
    logic [DEPTH-1:0] trk_valid_q, trk_valid_d;
    logic [1:0]       trk_rd_q [DEPTH];
    logic [1:0]       trk_rd_d [DEPTH];

    logic       read_rs1, read_rs2, hazard, accept;
    logic [7:0] opnd1, opnd2;

    assign read_rs1 = (op != OP_LI) && (op != OP_NOP);
    assign read_rs2 = read_rs1 && !imm_sel;

    assign wb_valid = trk_valid_q[ALU_LATENCY];
    assign wb_addr  = trk_rd_q[ALU_LATENCY];
    assign wb_data  = alu_result;

    // A source still inside the ALU must wait; one at write-back is bypassed.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        hazard = 1'b0;
        for (int k = 0; k < ALU_LATENCY; k++) begin
            if (trk_valid_q[k] && read_rs1 && (trk_rd_q[k] == rs1)) hazard = 1'b1;
            if (trk_valid_q[k] && read_rs2 && (trk_rd_q[k] == rs2)) hazard = 1'b1;
        end
    end

    assign opnd1       = (wb_valid && (wb_addr == rs1)) ? alu_result : rf_q[rs1];
    assign opnd2       = (wb_valid && (wb_addr == rs2)) ? alu_result : rf_q[rs2];
    assign instr_ready = !hazard;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        a_d            = a_q;
        b_d            = b_q;
        ctrl_d         = ctrl_q;
        trk_valid_d    = trk_valid_q << 1;
        trk_rd_d[0]    = rd;
        for (int k = 1; k < DEPTH; k++) trk_rd_d[k] = trk_rd_q[k-1];

        if (accept) begin
            if (op == OP_LI) begin
                a_d            = 8'd0;
                b_d            = imm8;
                ctrl_d         = ALU_ADD;
                trk_valid_d[0] = 1'b1;
            end else if (op != OP_NOP) begin
                a_d            = opnd1;
                b_d            = imm_sel ? imm8 : opnd2;
                ctrl_d         = op;
                trk_valid_d[0] = 1'b1;
            end
        end

        rf_d    = rf_q;
        carry_d = carry_q;
        if (wb_valid) begin
            rf_d[wb_addr] = alu_result;
            carry_d       = alu_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is reset because reads right after reset must return 0.
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'd0;
            for (int k = 0; k < DEPTH; k++) trk_rd_q[k] <= 2'd0;
            trk_valid_q <= '0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            ctrl_q      <= 3'd0;
            carry_q     <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            rf_q        <= rf_d;
            trk_rd_q    <= trk_rd_d;
            trk_valid_q <= trk_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            carry_q     <= carry_d;
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign control     = ctrl_q;
    assign issue_valid = trk_valid_q[0];
    assign carry_flag  = carry_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: one instance at ALU latency 1 and one at
// latency 3, each driven by a behavioural pipelined ALU.
module tb_id_issue_stage;

    logic clk, rst_n;
    int   total = 0;
    int   bad   = 0;

    logic        v1, rdy1, iv1, wbv1, cf1, co1;
    logic [15:0] in1;
    logic [7:0]  a1, b1, res1, wbd1;
    logic [2:0]  c1;
    logic [1:0]  wba1;

    logic        v3, rdy3, iv3, wbv3, cf3, co3;
    logic [15:0] in3;
    logic [7:0]  a3, b3, res3, wbd3;
    logic [2:0]  c3;
    logic [1:0]  wba3;

    id_issue_stage #(.ALU_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr(in1), .instr_ready(rdy1),
        .A(a1), .B(b1), .control(c1), .issue_valid(iv1), .alu_result(res1),
        .alu_cout(co1), .wb_valid(wbv1), .wb_addr(wba1), .wb_data(wbd1), .carry_flag(cf1)
    );

    id_issue_stage #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v3), .instr(in3), .instr_ready(rdy3),
        .A(a3), .B(b3), .control(c3), .issue_valid(iv3), .alu_result(res3),
        .alu_cout(co3), .wb_valid(wbv3), .wb_addr(wba3), .wb_data(wbd3), .carry_flag(cf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] c);
        case (c)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} + {1'b0, ~b} + 9'd1;
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            3'b101:  return {1'b0, a};
            default: return 9'd0;
        endcase
    endfunction

    logic [8:0] alu1_q;
    logic [8:0] alu3_q [3];
    always @(posedge clk) begin
        alu1_q    <= alu_f(a1, b1, c1);
        alu3_q[0] <= alu_f(a3, b3, c3);
        alu3_q[1] <= alu3_q[0];
        alu3_q[2] <= alu3_q[1];
    end
    assign res1 = alu1_q[7:0];
    assign co1  = alu1_q[8];
    assign res3 = alu3_q[2][7:0];
    assign co3  = alu3_q[2][8];

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic imm_sel,
                                        input logic [7:0] imm8);
        return {op, rd, rs1, imm_sel, imm8};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        v1 = 1'b0; in1 = 16'hE000;
        v3 = 1'b0; in3 = 16'hE000;
        tick();
        tick();
        check("rst_A", a1, 0);
        check("rst_B", b1, 0);
        check("rst_control", c1, 0);
        check("rst_issue_valid", iv1, 0);
        check("rst_wb_valid", wbv1, 0);
        check("rst_carry", cf1, 0);
        rst_n = 1'b1;

        // LI r1,5 then LI r2,12 back to back
        v1 = 1'b1; in1 = enc(3'b110, 2'd1, 2'd0, 1'b0, 8'd5);
        #1 check("li1_ready", rdy1, 1);
        tick();
        check("li1_issue", {iv1, a1, b1, c1}, {1'b1, 8'd0, 8'd5, 3'd0});
        in1 = enc(3'b110, 2'd2, 2'd0, 1'b0, 8'd12);
        #1 check("li2_ready", rdy1, 1);
        check("li1_no_wb_yet", wbv1, 0);
        tick();
        // OR r3,r1,r2 must stall while LI r2 sits in stage 0
        in1 = enc(3'b011, 2'd3, 2'd1, 1'b0, 8'd2);
        #1 check("or_stall", rdy1, 0);
        check("wb_li1", {wbv1, wba1, wbd1}, {1'b1, 2'd1, 8'd5});
        tick();
        check("stall_bubble", iv1, 0);
        check("wb_li2", {wbv1, wba1, wbd1}, {1'b1, 2'd2, 8'd12});
        check("or_ready_bypass", rdy1, 1);
        tick();
        check("or_issue", {iv1, a1, b1, c1}, {1'b1, 8'd5, 8'd12, 3'b011});
        check("rf_r1", dut1.rf_q[1], 5);
        check("rf_r2", dut1.rf_q[2], 12);
        // ADD r0,r2,#250
        in1 = enc(3'b000, 2'd0, 2'd2, 1'b1, 8'd250);
        #1 check("add_ready", rdy1, 1);
        tick();
        check("add_issue", {a1, b1, c1}, {8'd12, 8'd250, 3'b000});
        check("wb_or", {wbv1, wba1, wbd1}, {1'b1, 2'd3, 8'd13});
        // SUB r1,r1,#7
        in1 = enc(3'b001, 2'd1, 2'd1, 1'b1, 8'd7);
        tick();
        check("sub_issue", {a1, b1, c1}, {8'd5, 8'd7, 3'b001});
        check("wb_add", {wbv1, wba1, wbd1}, {1'b1, 2'd0, 8'd6});
        in1 = enc(3'b111, 2'd0, 2'd0, 1'b0, 8'd0);
        tick();
        check("nop_issue_valid", iv1, 0);
        check("carry_after_add", cf1, 1);
        check("wb_sub", {wbv1, wba1, wbd1}, {1'b1, 2'd1, 8'hFE});
        // XOR r2,r1,r1 reads r1 through the write-back bypass
        in1 = enc(3'b100, 2'd2, 2'd1, 1'b0, 8'd1);
        #1 check("xor_ready", rdy1, 1);
        tick();
        check("xor_issue", {iv1, a1, b1, c1}, {1'b1, 8'hFE, 8'hFE, 3'b100});
        check("nop_no_wb", wbv1, 0);
        in1 = enc(3'b110, 2'd3, 2'd0, 1'b0, 8'd7);
        tick();
        check("wb_xor", {wbv1, wba1, wbd1}, {1'b1, 2'd2, 8'd0});
        in1 = enc(3'b110, 2'd0, 2'd0, 1'b0, 8'd9);
        tick();
        // Two LIs in flight; reset mid-cycle flushes them
        v1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("flush_outputs", {a1, b1, c1, iv1, wbv1, cf1}, 0);
        check("flush_rf", {dut1.rf_q[0], dut1.rf_q[1], dut1.rf_q[2], dut1.rf_q[3]}, 0);
        #2 rst_n = 1'b1;
        #1 check("flush_ready", rdy1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_wb", wbv1, 0);
        end
        check("flush_rf_after", {dut1.rf_q[0], dut1.rf_q[1], dut1.rf_q[2], dut1.rf_q[3]}, 0);

        // Latency 3: LI r1,9 then dependent ADD r2,r1,r1
        v3 = 1'b1; in3 = enc(3'b110, 2'd1, 2'd0, 1'b0, 8'd9);
        #1 check("l3_li_ready", rdy3, 1);
        tick();
        in3 = enc(3'b000, 2'd2, 2'd1, 1'b0, 8'd1);
        #1;
        n = 0;
        while (!rdy3 && n < 10) begin
            n++;
            tick();
        end
        check("l3_stall_cycles", n, 3);
        check("l3_wb_li", {wbv3, wba3, wbd3}, {1'b1, 2'd1, 8'd9});
        tick();
        v3 = 1'b0;
        check("l3_add_issue", {iv3, a3, b3, c3}, {1'b1, 8'd9, 8'd9, 3'b000});
        n = 1;
        while (!wbv3 && n < 10) begin
            n++;
            tick();
        end
        check("l3_wb_delay", n, 4);
        check("l3_wb_add", {wbv3, wba3, wbd3}, {1'b1, 2'd2, 8'd18});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
